// File: rtl/eth_axis_tx_buffer.sv
// ---------------------------------------------------------------------------
// eth_axis_tx_buffer
//
// Transmit buffer between the uDMA TX channel (slow s_clk_i domain, 32-bit
// words) and the MAC TX path (fast m_clk_i domain, 8-bit AXI-Stream).
// Each word is stored as {tuser, tlast, byte_count, tdata} in a dual-clock
// FIFO and serialised LSB byte first on the read side.
//
// Optional feature (macro ETH_TX_UNDERRUN_ABORT_EN):
//   When the FIFO runs dry in the middle of a frame, the frame is closed with
//   a single 0x00 byte flagged tlast=1/tuser=1, and the remaining words of
//   that frame are discarded when they arrive. Without the macro an underrun
//   only produces tvalid=0 gaps.
//
// Ports:
//   s_clk_i, s_rstn_i       write clock, async active-low reset
//   s_axis_tdata[31:0]      word data, byte 0 = [7:0] sent first
//   s_axis_byte_count[1:0]  valid bytes minus 1 (only meaningful with tlast)
//   s_axis_tvalid/tready    word handshake (tready = FIFO not full)
//   s_axis_tuser/tlast      frame error flag / last word of frame
//   m_clk_i, m_rstn_i       read clock, async active-low reset
//   m_axis_tdata[7:0]       byte data
//   m_axis_tvalid/tready    byte handshake
//   m_axis_tlast/tuser      last byte / error flag (only with tlast)
// ---------------------------------------------------------------------------

// Dual-clock FIFO with Gray-coded pointers and two-flop synchronisers.
// Holds exactly DEPTH entries. The read port is first-word-fall-through
// with a registered RAM read: rd_data/rd_valid describe the head entry.
module eth_axis_tx_buffer_dc_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 32
) (
  input  logic              wr_clk,
  input  logic              wr_rstn,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_clk,
  input  logic              rd_rstn,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_pop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [AW:0] wr_bin_reg, wr_gray_reg;
  logic [AW:0] rd_gray_s1_reg, rd_gray_s2_reg;
  logic [AW:0] wr_bin_next;
  logic        wr_en_reg;
  logic        full;
  logic        push;

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign full        = (wr_gray_reg == {~rd_gray_s2_reg[AW:AW-1], rd_gray_s2_reg[AW-2:0]});
  // wr_en_reg keeps tready low while reset is asserted.
  assign wr_ready    = wr_en_reg & ~full;
  assign push        = wr_valid & wr_ready;
  assign wr_bin_next = wr_bin_reg + {{AW{1'b0}}, push};

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wr_en_reg      <= 1'b0;
      wr_bin_reg     <= '0;
      wr_gray_reg    <= '0;
      rd_gray_s1_reg <= '0;
      rd_gray_s2_reg <= '0;
    end else begin
      wr_en_reg      <= 1'b1;
      wr_bin_reg     <= wr_bin_next;
      wr_gray_reg    <= wr_bin_next ^ (wr_bin_next >> 1);
      rd_gray_s1_reg <= rd_gray_reg;
      rd_gray_s2_reg <= rd_gray_s1_reg;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (push) begin
      mem[wr_bin_reg[AW-1:0]] <= wr_data;
    end
  end

  // ---------------- read domain ----------------
  logic [AW:0]       rd_bin_reg, rd_gray_reg;
  logic [AW:0]       wr_gray_s1_reg, wr_gray_s2_reg;
  logic [AW:0]       rd_bin_next, rd_gray_next;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  assign rd_bin_next  = rd_bin_reg + {{AW{1'b0}}, rd_pop & rd_valid_reg};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rd_bin_reg     <= '0;
      rd_gray_reg    <= '0;
      wr_gray_s1_reg <= '0;
      wr_gray_s2_reg <= '0;
      rd_valid_reg   <= 1'b0;
    end else begin
      rd_bin_reg     <= rd_bin_next;
      rd_gray_reg    <= rd_gray_next;
      wr_gray_s1_reg <= wr_gray_reg;
      wr_gray_s2_reg <= wr_gray_s1_reg;
      // Emptiness is judged against the already-synchronised write pointer,
      // so the RAM entry was written well before it is read below.
      rd_valid_reg   <= (rd_gray_next != wr_gray_s2_reg);
    end
  end

  // The read address follows the next head pointer, so a pop presents the
  // following entry on the very next cycle without a bubble.
  always_ff @(posedge rd_clk) begin
    rd_data_reg <= mem[rd_bin_next[AW-1:0]];
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
endmodule

module eth_axis_tx_buffer #(
  parameter int BUFFER_DEPTH = 32
) (
  input  logic        s_clk_i,
  input  logic        s_rstn_i,
  input  logic [31:0] s_axis_tdata,
  input  logic [1:0]  s_axis_byte_count,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic        m_clk_i,
  input  logic        m_rstn_i,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);
`ifdef ETH_TX_UNDERRUN_ABORT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  logic [35:0] fifo_rd_data;
  logic        fifo_valid;
  logic        fifo_pop;

  eth_axis_tx_buffer_dc_fifo #(
    .DATA_W (36),
    .DEPTH  (BUFFER_DEPTH)
  ) u_fifo (
    .wr_clk   (s_clk_i),
    .wr_rstn  (s_rstn_i),
    .wr_data  ({s_axis_tuser, s_axis_tlast, s_axis_byte_count, s_axis_tdata}),
    .wr_valid (s_axis_tvalid),
    .wr_ready (s_axis_tready),
    .rd_clk   (m_clk_i),
    .rd_rstn  (m_rstn_i),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_valid),
    .rd_pop   (fifo_pop)
  );

  // Head-of-FIFO fields
  logic [31:0] f_data;
  logic [1:0]  f_bc;
  logic        f_last;
  logic        f_user;
  assign f_data = fifo_rd_data[31:0];
  assign f_bc   = fifo_rd_data[33:32];
  assign f_last = fifo_rd_data[34];
  assign f_user = fifo_rd_data[35];

  state_t      state_reg;
  logic [31:0] hold_reg;
  logic        word_last_reg;
  logic        word_user_reg;
  logic [1:0]  last_idx_reg;
  logic [1:0]  idx_reg;
  logic [7:0]  tdata_reg;
  logic        tvalid_reg;
  logic        tlast_reg;
  logic        tuser_reg;

  logic        shift_hs;
  logic        at_last;
  logic [1:0]  idx_inc;
  logic        no_abort;
  logic        f_first_last;

  assign shift_hs     = tvalid_reg & m_axis_tready;
  assign at_last      = (idx_reg == last_idx_reg);
  assign idx_inc      = idx_reg + 2'd1;
  // Byte 0 of the head word is also the frame's last byte.
  assign f_first_last = f_last & (f_bc == 2'd0);

`ifdef ETH_TX_UNDERRUN_ABORT_EN
  // Set while the synthetic abort byte is on the output.
  logic abort_pend_reg;
  assign no_abort = ~abort_pend_reg;
`else
  assign no_abort = 1'b1;
`endif

  always_comb begin
    fifo_pop = 1'b0;
    case (state_reg)
      IDLE:    fifo_pop = fifo_valid;
      SHIFT:   fifo_pop = shift_hs & at_last & fifo_valid & no_abort;
`ifdef ETH_TX_UNDERRUN_ABORT_EN
      DROP:    fifo_pop = fifo_valid;
`endif
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge m_clk_i or negedge m_rstn_i) begin
    if (!m_rstn_i) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      word_last_reg  <= 1'b0;
      word_user_reg  <= 1'b0;
      last_idx_reg   <= 2'd0;
      idx_reg        <= 2'd0;
      tdata_reg      <= 8'h00;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tuser_reg      <= 1'b0;
`ifdef ETH_TX_UNDERRUN_ABORT_EN
      abort_pend_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_valid) begin
            hold_reg      <= f_data;
            word_last_reg <= f_last;
            word_user_reg <= f_user;
            last_idx_reg  <= f_last ? f_bc : 2'd3;
            idx_reg       <= 2'd0;
            tdata_reg     <= f_data[7:0];
            tlast_reg     <= f_first_last;
            tuser_reg     <= f_first_last & f_user;
            tvalid_reg    <= 1'b1;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_hs) begin
            if (!at_last) begin
              idx_reg   <= idx_inc;
              tdata_reg <= hold_reg[{idx_inc, 3'b000} +: 8];
              tlast_reg <= word_last_reg & (idx_inc == last_idx_reg);
              tuser_reg <= word_last_reg & (idx_inc == last_idx_reg) & word_user_reg;
`ifdef ETH_TX_UNDERRUN_ABORT_EN
            end else if (abort_pend_reg) begin
              // Abort byte accepted: flush the rest of the broken frame.
              abort_pend_reg <= 1'b0;
              tvalid_reg     <= 1'b0;
              tlast_reg      <= 1'b0;
              tuser_reg      <= 1'b0;
              state_reg      <= DROP;
`endif
            end else if (fifo_valid) begin
              // Back-to-back reload keeps one byte per cycle.
              hold_reg      <= f_data;
              word_last_reg <= f_last;
              word_user_reg <= f_user;
              last_idx_reg  <= f_last ? f_bc : 2'd3;
              idx_reg       <= 2'd0;
              tdata_reg     <= f_data[7:0];
              tlast_reg     <= f_first_last;
              tuser_reg     <= f_first_last & f_user;
`ifdef ETH_TX_UNDERRUN_ABORT_EN
            end else if (!word_last_reg) begin
              // Underrun mid-frame: terminate with an errored 0x00 byte.
              // idx stays at last_idx, so its handshake lands above.
              abort_pend_reg <= 1'b1;
              tdata_reg      <= 8'h00;
              tlast_reg      <= 1'b1;
              tuser_reg      <= 1'b1;
`endif
            end else begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              tuser_reg  <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
`ifdef ETH_TX_UNDERRUN_ABORT_EN
        DROP: begin
          if (fifo_valid && f_last) begin
            state_reg <= IDLE;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;
endmodule

// File: tb/tb_eth_axis_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_eth_axis_tx_buffer
//
// Directed bench for eth_axis_tx_buffer: word-to-byte ordering, byte_count
// truncation, tuser forwarding, random back-pressure with hold checks, FIFO
// fill to full, reset mid-frame and the underrun behaviour selected by
// ETH_TX_UNDERRUN_ABORT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_axis_tx_buffer;
  logic        s_clk = 1'b0;
  logic        m_clk = 1'b0;
  logic        s_rstn = 1'b0;
  logic        m_rstn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [1:0]  s_axis_byte_count = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  int compared = 0;
  int failed   = 0;
  int m_cycle  = 0;
  int hs_cycle = 0;
  bit stall_seen = 1'b0;
  logic [9:0] stall_val = '0;

  always #10 s_clk = ~s_clk;
  always #3  m_clk = ~m_clk;
  always @(posedge m_clk) m_cycle <= m_cycle + 1;

  eth_axis_tx_buffer #(.BUFFER_DEPTH(32)) dut (
    .s_clk_i           (s_clk),
    .s_rstn_i          (s_rstn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_byte_count (s_axis_byte_count),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_clk_i           (m_clk),
    .m_rstn_i          (m_rstn),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One word on the slow side; bounded wait for tready.
  task automatic s_write(input logic [31:0] d, input logic [1:0] bc, input logic last,
                         input logic user, input string tag);
    int waited = 0;
    @(negedge s_clk);
    s_axis_tdata      = d;
    s_axis_byte_count = bc;
    s_axis_tlast      = last;
    s_axis_tuser      = user;
    s_axis_tvalid     = 1'b1;
    while (!s_axis_tready && waited < 300) begin
      @(negedge s_clk);
      waited++;
    end
    check({tag, "_accept"}, {31'd0, s_axis_tready}, 32'd1);
    if (s_axis_tready) @(posedge s_clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  // Receive one byte; drives tready at each falling edge (1 or random),
  // checks the byte on its handshake and that stalled outputs hold.
  task automatic m_recv(input logic [7:0] d, input logic last, input logic user,
                        input bit rnd, input string tag);
    int waited = 0;
    bit done = 1'b0;
    while (!done && waited < 2000) begin
      @(negedge m_clk);
      waited++;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        done     = 1'b1;
        hs_cycle = m_cycle;
        check({tag, "_data"}, {24'd0, m_axis_tdata}, {24'd0, d});
        check({tag, "_last"}, {31'd0, m_axis_tlast}, {31'd0, last});
        check({tag, "_user"}, {31'd0, m_axis_tuser}, {31'd0, user});
        stall_seen = 1'b0;
        @(posedge m_clk);
        #1;
      end else if (m_axis_tvalid) begin
        if (stall_seen)
          check({tag, "_hold"}, {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, stall_val});
        stall_seen = 1'b1;
        stall_val  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end else begin
        stall_seen = 1'b0;
      end
    end
    check({tag, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [7:0] pat(input int i, input bit ramp);
    return ramp ? 8'(i) : 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] pat_word(input int k, input bit ramp);
    return {pat(4*k+3, ramp), pat(4*k+2, ramp), pat(4*k+1, ramp), pat(4*k, ramp)};
  endfunction

  initial begin
    int prev;
    bit stayed_low;
    logic [7:0] t1_bytes [7];
    t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    // ---- reset state ----
    repeat (5) @(negedge s_clk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("rst_tuser",  {31'd0, m_axis_tuser},  32'd0);
    check("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    s_rstn = 1'b1;
    m_rstn = 1'b1;
    repeat (4) @(negedge s_clk);
    check("post_rst_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // ---- 1: two-word frame, 7 bytes back-to-back ----
    s_write(32'h44332211, 2'd0, 1'b0, 1'b0, "t1_w0");
    s_write(32'h00776655, 2'd2, 1'b1, 1'b0, "t1_w1");
    repeat (20) @(negedge m_clk);
    check("t1_preload_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t1_preload_data",  {24'd0, m_axis_tdata},  32'h11);
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      m_recv(t1_bytes[i], i == 6, 1'b0, 1'b0, "t1_rx");
      if (i > 0) check("t1_gap", hs_cycle - prev, 32'd1);
      prev = hs_cycle;
    end
    @(negedge m_clk);
    check("t1_end_valid", {31'd0, m_axis_tvalid}, 32'd0);

    // ---- 2: single-byte frame with error flag ----
    s_write(32'hAABBCCDD, 2'd0, 1'b1, 1'b1, "t2_w");
    m_recv(8'hDD, 1'b1, 1'b1, 1'b0, "t2_rx");
    @(negedge m_clk);
    check("t2_end_valid", {31'd0, m_axis_tvalid}, 32'd0);

    // ---- 3: 64-byte frame under random back-pressure ----
    m_axis_tready = 1'b0;
    for (int k = 0; k < 16; k++)
      s_write(pat_word(k, 1'b0), 2'd3, k == 15, 1'b0, "t3_w");
    for (int i = 0; i < 64; i++)
      m_recv(pat(i, 1'b0), i == 63, 1'b0, 1'b1, "t3_rx");

    // ---- 4: fill to full, then drain 160 bytes ----
    @(negedge m_clk);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 33; k++)
      s_write(pat_word(k, 1'b1), 2'd3, 1'b0, 1'b0, "t4_fill");
    repeat (10) @(negedge s_clk);
    check("t4_full_tready", {31'd0, s_axis_tready}, 32'd0);
    fork
      begin
        for (int k = 33; k < 40; k++)
          s_write(pat_word(k, 1'b1), 2'd3, k == 39, 1'b0, "t4_wr");
      end
      begin
        for (int i = 0; i < 160; i++)
          m_recv(pat(i, 1'b1), i == 159, 1'b0, 1'b0, "t4_rx");
      end
    join

    // ---- 5: reset in the middle of a frame ----
    s_write(32'h13121110, 2'd0, 1'b0, 1'b0, "t5_w0");
    s_write(32'h17161514, 2'd3, 1'b1, 1'b1, "t5_w1");
    m_recv(8'h10, 1'b0, 1'b0, 1'b0, "t5_rx");
    m_recv(8'h11, 1'b0, 1'b0, 1'b0, "t5_rx");
    m_rstn = 1'b0;
    s_rstn = 1'b0;
    #1;
    check("t5_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t5_rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("t5_rst_tuser",  {31'd0, m_axis_tuser},  32'd0);
    check("t5_rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    repeat (3) @(negedge s_clk);
    s_rstn = 1'b1;
    m_rstn = 1'b1;
    stayed_low = 1'b1;
    repeat (20) begin
      @(negedge m_clk);
      if (m_axis_tvalid) stayed_low = 1'b0;
    end
    check("t5_no_stale", {31'd0, stayed_low}, 32'd1);
    s_write(32'h24232221, 2'd3, 1'b1, 1'b0, "t5_w2");
    for (int i = 0; i < 4; i++)
      m_recv(8'(8'h21 + i), i == 3, 1'b0, 1'b0, "t5_rx2");
    @(negedge m_clk);
    check("t5_end_valid", {31'd0, m_axis_tvalid}, 32'd0);

    // ---- 6: underrun mid-frame ----
    s_write(32'h04030201, 2'd0, 1'b0, 1'b0, "t6_w0");
    for (int i = 0; i < 4; i++)
      m_recv(8'(i + 1), 1'b0, 1'b0, 1'b0, "t6_rx");
`ifdef ETH_TX_UNDERRUN_ABORT_EN
    m_recv(8'h00, 1'b1, 1'b1, 1'b0, "t6_abort");
    s_write(32'h08070605, 2'd0, 1'b0, 1'b0, "t6_w1");
    s_write(32'h0C0B0A09, 2'd3, 1'b1, 1'b0, "t6_w2");
    s_write(32'h0000BEEF, 2'd1, 1'b1, 1'b0, "t6_w3");
    m_recv(8'hEF, 1'b0, 1'b0, 1'b0, "t6_next");
    m_recv(8'hBE, 1'b1, 1'b0, 1'b0, "t6_next");
`else
    repeat (10) @(negedge m_clk);
    check("t6_gap_valid", {31'd0, m_axis_tvalid}, 32'd0);
    s_write(32'h08070605, 2'd2, 1'b1, 1'b0, "t6_w1");
    for (int i = 0; i < 3; i++)
      m_recv(8'(i + 5), i == 2, 1'b0, 1'b0, "t6_resume");
`endif
    @(negedge m_clk);
    check("t6_end_valid", {31'd0, m_axis_tvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
